// File: rtl/id_stage_hs_pkg.sv
// id_stage_hs_pkg: opcodes, function classes, writeback partition codes and immediate-func list
package id_stage_hs_pkg;
    typedef enum logic [5:0] {
        OP_LD  = 6'b100000,
        OP_ST  = 6'b100001,
        OP_ALU = 6'b101010,
        OP_NOP = 6'b111100
    } op_e;
    typedef enum logic [1:0] {CLS_ALU, CLS_LD, CLS_ST, CLS_NOP} cls_e;
    typedef enum logic [2:0] {PPP_FULL, PPP_TAIL, PPP_HEAD, PPP_EVEN, PPP_ODD} ppp_e;
    localparam logic [3:0] IMM_FN_A = 4'b1011;
    localparam logic [3:0] IMM_FN_B = 4'b1101;
    localparam logic [3:0] IMM_FN_C = 4'b1111;
    function automatic logic is_imm_func(input logic [3:0] f);
        return f == IMM_FN_A || f == IMM_FN_B || f == IMM_FN_C;
    endfunction
endpackage

// File: rtl/wb_lane_mask.sv
// wb_lane_mask: expands a writeback partition code {PPP, WW} into a per-bit write mask
module wb_lane_mask
    import id_stage_hs_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [0:4]        pppww,
    output logic [0:DATA_W-1] mask
);
    logic [2:0] ppp;
    logic [1:0] ww;
    assign {ppp, ww} = pppww;
    // element parity of bit i is bit (3+WW) of its big-endian position
    always_comb begin
        mask = '0;
        for (int i = 0; i < DATA_W; i++)
            mask[i] = ppp == PPP_FULL ? 1'b1
                    : ppp == PPP_TAIL ? (i >= DATA_W / 2)
                    : ppp == PPP_HEAD ? (i < DATA_W / 2)
                    : ppp == PPP_EVEN ? (((i >> (3 + int'(ww))) & 1) == 0)
                    : ppp == PPP_ODD  ? (((i >> (3 + int'(ww))) & 1) != 0 && ww != 2'b11)
                    : 1'b0;
    end
endmodule

// File: rtl/id_stage_hs.sv
// id_stage_hs: handshaked decode stage with masked-writeback register file, bypass and stall refresh
module id_stage_hs
    import id_stage_hs_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int REG_N  = 32,
    parameter int RIDX_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [0:31]       IF_instruction,
    input  logic              IF_valid,
    output logic              ID_ready,
    input  logic              ALU_WB_en,
    input  logic [0:RIDX_W-1] WB_rD,
    input  logic [0:4]        WB_PPPWW,
    input  logic [0:DATA_W-1] WB_data,
    input  logic              EX_ready,
    output logic              ID_valid,
    output logic [0:5]        ID_function_bit,
    output logic [0:4]        ID_rD,
    output logic [0:4]        ID_PPPWW,
    output logic [0:DATA_W-1] ID_rA_data,
    output logic [0:DATA_W-1] ID_rB_data,
    output logic              ID_WB_en,
    output logic              ID_wmem_en
);
    logic [0:DATA_W-1] regs [REG_N];
    logic [0:DATA_W-1] wmask, wb_merged, val_a, val_b, d_a, d_b;
    logic [5:0]        op, d_fn;
    logic [4:0]        f_d, f_a, f_b;
    logic [RIDX_W-1:0] src_a, src_b, a_i, b_i;
    logic              wr, d_af, d_bf, d_wb, d_wm, a_f, b_f, unused_bits;

    wb_lane_mask #(.DATA_W(DATA_W)) u_mask (.pppww(WB_PPPWW), .mask(wmask));

    assign ID_ready    = EX_ready || !ID_valid;
    assign op          = IF_instruction[0:5];
    assign f_d         = IF_instruction[6:10];
    assign f_a         = IF_instruction[11:15];
    assign f_b         = IF_instruction[16:20];
    assign unused_bits = ^IF_instruction[26:27];
    assign wr          = ALU_WB_en && WB_rD != '0;
    assign wb_merged   = (regs[WB_rD] & ~wmask) | (WB_data & wmask);
    assign src_a       = op == OP_ST ? f_d[RIDX_W-1:0] : f_a[RIDX_W-1:0];
    assign src_b       = f_b[RIDX_W-1:0];
    // a read of the register being written sees the post-write value
    assign val_a = src_a == '0 ? '0 : (wr && src_a == WB_rD) ? wb_merged : regs[src_a];
    assign val_b = src_b == '0 ? '0 : (wr && src_b == WB_rD) ? wb_merged : regs[src_b];

    always_comb begin
        d_fn = {CLS_NOP, 4'b0000};
        d_a  = '0;
        d_b  = '0;
        d_af = 1'b0;
        d_bf = 1'b0;
        d_wb = 1'b0;
        d_wm = 1'b0;
        case (op)
            OP_ALU: begin
                d_fn = {CLS_ALU, IF_instruction[28:31]};
                d_a  = val_a;
                d_af = 1'b1;
                d_bf = !is_imm_func(IF_instruction[28:31]);
                d_b  = d_bf ? val_b : DATA_W'(f_b);
                d_wb = 1'b1;
            end
            OP_LD: begin
                d_fn = {CLS_LD, 4'b0000};
                d_b  = DATA_W'(IF_instruction[16:31]);
                d_wb = 1'b1;
            end
            OP_ST: begin
                d_fn = {CLS_ST, 4'b0000};
                d_a  = val_a;
                d_af = 1'b1;
                d_b  = DATA_W'(IF_instruction[16:31]);
                d_wm = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < REG_N; i++) regs[i] <= '0;
            ID_valid        <= 1'b0;
            ID_function_bit <= '0;
            ID_rD           <= '0;
            ID_PPPWW        <= '0;
            ID_rA_data      <= '0;
            ID_rB_data      <= '0;
            ID_WB_en        <= 1'b0;
            ID_wmem_en      <= 1'b0;
            a_f             <= 1'b0;
            b_f             <= 1'b0;
            a_i             <= '0;
            b_i             <= '0;
        end else begin
            if (wr) regs[WB_rD] <= wb_merged;
            if (ID_ready) begin
                ID_valid        <= IF_valid;
                ID_function_bit <= IF_valid ? d_fn : {CLS_NOP, 4'b0000};
                ID_rD           <= IF_valid ? f_d : '0;
                ID_PPPWW        <= IF_valid ? IF_instruction[21:25] : '0;
                ID_rA_data      <= IF_valid ? d_a : '0;
                ID_rB_data      <= IF_valid ? d_b : '0;
                ID_WB_en        <= IF_valid && d_wb;
                ID_wmem_en      <= IF_valid && d_wm;
                a_f             <= IF_valid && d_af;
                b_f             <= IF_valid && d_bf;
                a_i             <= src_a;
                b_i             <= src_b;
            end else begin
                // held operands track writebacks to their source registers
                if (wr && a_f && a_i == WB_rD) ID_rA_data <= (ID_rA_data & ~wmask) | (WB_data & wmask);
                if (wr && b_f && b_i == WB_rD) ID_rB_data <= (ID_rB_data & ~wmask) | (WB_data & wmask);
            end
        end
    end
endmodule

// File: doc/id_stage_hs.md
Name: id_stage_hs

Overview:
Parametrised next-generation instruction-decode stage. Sits between IF and the ALU/MEM stage. Decodes 32-bit instructions and reads operands from an internal register file. Generalised over register width and register count, with writeback lane masking derived from the data width. Adds what the previous decode stage lacks: valid/ready handshaking with downstream stall, write-to-read bypass, and refresh of operands held during a stall.

Parameters:
DATA_W, 64, register/operand width; power of two, minimum 64
REG_N, 32, register count; power of two, maximum 32; register 0 reads zero
RIDX_W, 5, register index width, equal to log2(REG_N); index fields are instruction bits [6:10], [11:15], [16:20], truncated to the low RIDX_W bits

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  synchronous, active-low reset
IF_instruction  in  [0:31]  instruction; bit 0 is the MSB
IF_valid  in  1  IF_instruction is valid
ID_ready  out  1  stage accepts an instruction this cycle
ALU_WB_en  in  1  writeback enable
WB_rD  in  [0:RIDX_W-1]  writeback register index
WB_PPPWW  in  [0:4]  writeback partition code
WB_data  in  [0:DATA_W-1]  writeback data
EX_ready  in  1  downstream accepts the output
ID_valid  out  1  output payload is valid
ID_function_bit  out  [0:5]  {class[1:0], func[3:0]}
ID_rD  out  [0:4]  destination field, instruction bits [6:10]
ID_PPPWW  out  [0:4]  instruction bits [21:25]
ID_rA_data  out  [0:DATA_W-1]  operand A
ID_rB_data  out  [0:DATA_W-1]  operand B
ID_WB_en  out  1  register writeback request
ID_wmem_en  out  1  memory write request

Behaviour:
- Reset (rst==0 at posedge):
  - All outputs 0, including ID_valid=0 and ID_function_bit=0.
  - Registers 1..REG_N-1 cleared.
  - Internal held source indices and source flags cleared.
  - Reset overrides all other events, including reset mid-stall.
- Handshake:
  - ID_ready = EX_ready || !ID_valid, combinational.
  - Transfer into the stage occurs when IF_valid && ID_ready.
  - Output is consumed when ID_valid && EX_ready.
- Latency is 1 cycle: an accepted instruction is presented on outputs the next cycle.
- If ID_ready && !IF_valid, the output register loads a bubble:
  - ID_valid=0
  - function 110000
  - rA=rB=0
  - WB_en=0, wmem_en=0
- If !ID_ready, all outputs hold, except operand refresh (below).
- Decode (opcode = IF_instruction[0:5]). All instructions set rD=[6:10] and PPPWW=[21:25].
  - 101010 (ALU):
    - function = {00, [28:31]}; rA = R[[11:15]].
    - rB = zero-extended [16:20] when func is 1011, 1101 or 1111; otherwise rB = R[[16:20]].
    - WB_en=1, wmem_en=0.
  - 100000 (load): function 010000, rA=0, rB=zero-extended [16:31], WB_en=1, wmem_en=0.
  - 100001 (store): function 100000, rA=R[[6:10]], rB=zero-extended [16:31], WB_en=0, wmem_en=1.
  - 111100 and any other opcode (NOP): function 110000, rA=rB=0, WB_en=0, wmem_en=0.
- Writeback mask, driven by WB_PPPWW = {PPP, WW}:
  - Element width E = 8<<WW; element k occupies bits [k*E : k*E+E-1].
  - PPP=000: full register.
  - PPP=001: bits [DATA_W/2 : DATA_W-1].
  - PPP=010: bits [0 : DATA_W/2-1].
  - PPP=011: even-indexed elements.
  - PPP=100: odd-indexed elements; when WW=11, no write.
  - PPP=101..111: no write.
  - A write occurs only when ALU_WB_en==1 and WB_rD!=0; unmasked bits are retained.
- Bypass:
  - An operand read of register r in the same cycle as a write to r (r!=0) returns the merged value (old bits outside the mask, WB_data bits inside).
  - Register 0 always reads 0 and writes to it are ignored.
- Operand refresh during stall:
  - Each register-sourced operand keeps its source index and a source flag; immediate and zero operands have flag 0.
  - While !ID_ready, a writeback hitting a flagged source index merges into the held rA/rB under the same mask.
  - Refresh and new acceptance never coincide, because acceptance requires ID_ready.
- Simultaneous accept and writeback: the accepted instruction sees the bypassed (post-write) value.

Decomposition:
- Shared package holds:
  - opcode constants (OP_ALU 101010, OP_LD 100000, OP_ST 100001, OP_NOP 111100)
  - function-class constants (00 ALU, 01 LD, 10 ST, 11 NOP)
  - PPP encodings
  - immediate-func list {1011, 1101, 1111}
- Sub-module wb_lane_mask:
  - Combinational, parametrised by DATA_W.
  - Maps WB_PPPWW to a [0:DATA_W-1] write mask.
  - Instanced once and shared by the register-file write, the bypass path and the stall refresh.

Test Plan:
- Reset and register writes:
  - Hold rst=0 for 2 cycles, then release.
  - Write R1=0x0123456789ABCDEF with PPPWW=00000.
  - Then write WB_data=0xFFFF..FF to R1 with PPPWW=01100.
  - Then issue ALU 101010 with rA=1, func 0000 -> rA_data=0xFF23FF67FFABFFEF.
- Immediate operand: issue ALU func 1101 with [16:20]=7 -> rB_data=7 and ID_function_bit=001101.
- Store decode: issue store with rD=3 (R3=0x55), imm 0x1234 -> function 100000, rA=0x55, rB=0x1234, WB_en=0, wmem_en=1.
- Same-cycle bypass: write R2=0xAA with PPPWW=00000 in the same cycle R2 is read -> next-cycle rA_data=0xAA.
- Stall refresh:
  - Hold EX_ready=0 with an R4-sourced operand held on the outputs.
  - Write R4=0x99 -> rA_data becomes 0x99; all other outputs are unchanged; ID_ready=0.
- Bubble and reset mid-stall:
  - IF_valid=0 with EX_ready=1 -> ID_valid=0, function 110000.
  - Assert rst=0 during a stall -> all outputs 0 on the next posedge.
